// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word memory behind the memory pipeline stage.
// Define DMEM_BYTE_ACCESS_EN to add the ByteM input and byte-lane access.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
`ifdef DMEM_BYTE_ACCESS_EN
  input  logic        ByteM,
`endif
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReady,
  output logic        MemErr,
  output logic        MemStall
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_enter_resp;

  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_write;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_write;
  logic          w_byte;
  logic [IW-1:0] w_idx;
  logic [4:0]    w_lane;
  logic          w_range_err;
  logic          w_err;
  logic [31:0]   w_word;
  logic [31:0]   w_load;
  logic          w_commit;

  // With zero wait states the response is produced on the accepting
  // edge, so the request is taken live from the ports while in IDLE.
`ifdef DMEM_BYTE_ACCESS_EN
  logic r_byte;
  assign w_byte = (r_state == S_IDLE) ? ByteM : r_byte;
`else
  assign w_byte = 1'b0;
`endif

  assign w_addr  = (r_state == S_IDLE) ? ALUOutM    : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? WriteDataM : r_wdata;
  assign w_write = (r_state == S_IDLE) ? MemWrite   : r_write;

  assign w_idx       = w_addr[IW+1:2];
  assign w_lane      = {w_addr[1:0], 3'b000};
  assign w_range_err = {2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_err       = w_range_err | (~w_byte & (|w_addr[1:0]));

  assign w_word = mem[w_idx];
  assign w_load = w_byte ? {24'h0, w_word[w_lane +: 8]} : w_word;

  assign w_commit = reset & w_enter_resp & w_write & ~w_err;

  // Next-state and wait-counter decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (MemReq) begin
          w_cnt_nxt = CW'(WAIT_STATES);
          if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter, request latch and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
`ifdef DMEM_BYTE_ACCESS_EN
      r_byte  <= 1'b0;
`endif
      r_rdata <= RESET_RDATA;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && MemReq) begin
        r_addr  <= ALUOutM;
        r_wdata <= WriteDataM;
        r_write <= MemWrite;
`ifdef DMEM_BYTE_ACCESS_EN
        r_byte  <= ByteM;
`endif
      end
      if (w_enter_resp) begin
        r_err <= w_err;
        if (!w_write) begin
          r_rdata <= w_err ? RESET_RDATA : w_load;
        end
      end
    end
  end

  // Store commit; the array is never cleared by reset
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (w_byte) begin
        mem[w_idx][w_lane +: 8] <= w_wdata[7:0];
      end else begin
        mem[w_idx] <= w_wdata;
      end
    end
  end

  assign MemReady  = (r_state == S_RESP);
  assign MemErr    = MemReady & r_err;
  assign MemStall  = MemReq & ~MemReady;
  assign ReadDataM = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder.
// Byte-access scenarios are included when DMEM_BYTE_ACCESS_EN is defined.
module tb_dmem_responder;

  localparam int          DEPTH  = 64;
  localparam int          WS     = 2;
  localparam logic [31:0] RST_RD = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wd, rd;
  logic        rdy, err, stall;
`ifdef DMEM_BYTE_ACCESS_EN
  logic        byt;
  logic        zb;
`endif

  logic        zq, zw;
  logic [31:0] za, zd, zr;
  logic        zy, ze, zs;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;
  bit          prev_keep;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS),
    .RESET_RDATA(RST_RD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemReq    (req),
    .MemWrite  (we),
`ifdef DMEM_BYTE_ACCESS_EN
    .ByteM     (byt),
`endif
    .ALUOutM   (addr),
    .WriteDataM(wd),
    .ReadDataM (rd),
    .MemReady  (rdy),
    .MemErr    (err),
    .MemStall  (stall)
  );

  dmem_responder #(
    .DEPTH_WORDS(16),
    .WAIT_STATES(0),
    .RESET_RDATA(RST_RD)
  ) dut0 (
    .clk       (clk),
    .reset     (reset),
    .MemReq    (zq),
    .MemWrite  (zw),
`ifdef DMEM_BYTE_ACCESS_EN
    .ByteM     (zb),
`endif
    .ALUOutM   (za),
    .WriteDataM(zd),
    .ReadDataM (zr),
    .MemReady  (zy),
    .MemErr    (ze),
    .MemStall  (zs)
  );

  // Reference: word array indexed by addr/4, updated by the request rules.
  task automatic model_xact(input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input bit b,
                            output logic [31:0] er, output logic ee);
    int unsigned idx;
    int unsigned lane;
    idx  = a / 4;
    lane = a % 4;
    ee   = (idx >= DEPTH) || (!b && lane != 0);
    if (wr) begin
      if (!ee) begin
        if (b)
          model[idx] = (model[idx] & ~(32'hFF << (8 * lane)))
                     | ((d & 32'hFF) << (8 * lane));
        else
          model[idx] = d;
      end
    end else begin
      if (ee)     last_rd = RST_RD;
      else if (b) last_rd = (model[idx] >> (8 * lane)) & 32'hFF;
      else        last_rd = model[idx];
    end
    er = last_rd;
  endtask

  // Drives one request from a negedge; returns edges to MemReady,
  // response values and the number of bad MemStall samples.
  task automatic run_xact(input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit b,
                          input bit keep, output int lat,
                          output logic [31:0] r, output logic e,
                          output int sbad);
    req  = 1'b1;
    we   = wr;
    addr = a;
    wd   = d;
`ifdef DMEM_BYTE_ACCESS_EN
    byt  = b;
`else
    if (b) sbad = 0;
`endif
    lat  = 0;
    sbad = 0;
    #1;
    if (rdy !== 1'b1 && stall !== 1'b1) sbad++;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rdy !== 1'b1 && stall !== 1'b1) sbad++;
    end while (rdy !== 1'b1 && lat < 20);
    r = rd;
    e = err;
    if (rdy === 1'b1 && stall !== 1'b0) sbad++;
    prev_keep = keep;
    if (!keep) begin
      req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (rdy !== 1'b0 || stall !== 1'b0 || err !== 1'b0) sbad++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rdy !== 1'b0 || err !== 1'b0 || rd !== RST_RD || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset rdy=%b err=%b rd=%h stall=%b exp 0 0 %h 0",
               rdy, err, rd, stall, RST_RD);
    end
    checks++;
    if (zy !== 1'b0 || ze !== 1'b0 || zr !== RST_RD) begin
      errors++;
      $display("FAIL reset0 rdy=%b err=%b rd=%h exp 0 0 %h", zy, ze, zr, RST_RD);
    end
  endtask

  task automatic test_fill();
    logic [31:0] d, er, r;
    logic        ee, e;
    int          lat, sb, xl;
    for (int i = 0; i < DEPTH; i++) begin
      d  = $urandom;
      xl = prev_keep ? WS + 2 : WS + 1;
      model_xact(1'b1, 32'(i * 4), d, 1'b0, er, ee);
      run_xact(1'b1, 32'(i * 4), d, 1'b0, 1'b0, lat, r, e, sb);
      checks++;
      if (lat !== xl || r !== er || e !== ee || sb != 0) begin
        errors++;
        $display("FAIL fill[%0d] lat %0d/%0d rd %h/%h err %b/%b stallbad %0d",
                 i, lat, xl, r, er, e, ee, sb);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] er, r;
    logic        ee, e;
    int          lat, sb;
    model_xact(1'b1, 32'h10, 32'hCAFEBABE, 1'b0, er, ee);
    run_xact(1'b1, 32'h10, 32'hCAFEBABE, 1'b0, 1'b0, lat, r, e, sb);
    checks++;
    if (lat !== 3 || e !== 1'b0 || r !== er || sb != 0) begin
      errors++;
      $display("FAIL store10 lat %0d/3 err %b/0 rd %h/%h stallbad %0d",
               lat, e, r, er, sb);
    end
    model_xact(1'b0, 32'h10, 32'h0, 1'b0, er, ee);
    run_xact(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, lat, r, e, sb);
    checks++;
    if (lat !== 3 || e !== 1'b0 || r !== 32'hCAFEBABE || sb != 0) begin
      errors++;
      $display("FAIL load10 lat %0d/3 err %b/0 rd %h/cafebabe stallbad %0d",
               lat, e, r, sb);
    end
  endtask

  task automatic test_errors();
    logic [31:0] er, r;
    logic        ee, e;
    int          lat, sb;
    model_xact(1'b0, 32'h102, 32'h0, 1'b0, er, ee);
    run_xact(1'b0, 32'h102, 32'h0, 1'b0, 1'b0, lat, r, e, sb);
    checks++;
    if (lat !== WS + 1 || e !== 1'b1 || r !== RST_RD || sb != 0) begin
      errors++;
      $display("FAIL load102 lat %0d/%0d err %b/1 rd %h/%h stallbad %0d",
               lat, WS + 1, e, r, RST_RD, sb);
    end
    model_xact(1'b1, 32'h100, 32'h5A5A5A5A, 1'b0, er, ee);
    run_xact(1'b1, 32'h100, 32'h5A5A5A5A, 1'b0, 1'b0, lat, r, e, sb);
    checks++;
    if (lat !== WS + 1 || e !== 1'b1 || r !== er || sb != 0) begin
      errors++;
      $display("FAIL store100 lat %0d/%0d err %b/1 rd %h/%h stallbad %0d",
               lat, WS + 1, e, r, er, sb);
    end
    for (int i = 0; i < 2; i++) begin
      model_xact(1'b0, 32'(i * 252), 32'h0, 1'b0, er, ee);
      run_xact(1'b0, 32'(i * 252), 32'h0, 1'b0, 1'b0, lat, r, e, sb);
      checks++;
      if (e !== 1'b0 || r !== er) begin
        errors++;
        $display("FAIL unchanged[%0d] err %b/0 rd %h/%h", i, e, r, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er, r;
    logic        ee, e;
    int          lat, sb, xl;
    for (int i = 0; i < 3; i++) begin
      xl = prev_keep ? WS + 2 : WS + 1;
      model_xact(1'b0, 32'(i * 4), 32'h0, 1'b0, er, ee);
      run_xact(1'b0, 32'(i * 4), 32'h0, 1'b0, i < 2, lat, r, e, sb);
      checks++;
      if (lat !== xl || r !== er || e !== 1'b0 || sb != 0) begin
        errors++;
        $display("FAIL b2b[%0d] lat %0d/%0d rd %h/%h err %b/0 stallbad %0d",
                 i, lat, xl, r, er, e, sb);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, er, r;
    logic        ee, e;
    bit          wr, b, keep;
    int          lat, sb, xl;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'($urandom_range(64, 80) * 4);
        1:       a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        default: a = 32'($urandom_range(0, 63) * 4);
      endcase
`ifdef DMEM_BYTE_ACCESS_EN
      b = ($urandom_range(0, 2) == 0);
`else
      b = 1'b0;
`endif
      wr   = $urandom_range(0, 1) == 1;
      keep = (i < 149) && ($urandom_range(0, 2) == 0);
      d    = $urandom;
      xl   = prev_keep ? WS + 2 : WS + 1;
      model_xact(wr, a, d, b, er, ee);
      run_xact(wr, a, d, b, keep, lat, r, e, sb);
      checks++;
      if (lat !== xl || r !== er || e !== ee || sb != 0) begin
        errors++;
        $display("FAIL rand[%0d] a=%h wr=%b lat %0d/%0d rd %h/%h err %b/%b sb %0d",
                 i, a, wr, lat, xl, r, er, e, ee, sb);
      end
    end
  endtask

`ifdef DMEM_BYTE_ACCESS_EN
  task automatic test_byte();
    logic [31:0] er, r;
    logic        ee, e;
    int          lat, sb;
    model_xact(1'b1, 32'h20, 32'h11223344, 1'b0, er, ee);
    run_xact(1'b1, 32'h20, 32'h11223344, 1'b0, 1'b0, lat, r, e, sb);
    model_xact(1'b1, 32'h21, 32'h000000AA, 1'b1, er, ee);
    run_xact(1'b1, 32'h21, 32'h000000AA, 1'b1, 1'b0, lat, r, e, sb);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL bytestore err %b/0", e);
    end
    model_xact(1'b0, 32'h20, 32'h0, 1'b0, er, ee);
    run_xact(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, lat, r, e, sb);
    checks++;
    if (r !== 32'h1122AA44 || e !== 1'b0) begin
      errors++;
      $display("FAIL wordload20 rd %h/1122aa44 err %b/0", r, e);
    end
    model_xact(1'b0, 32'h23, 32'h0, 1'b1, er, ee);
    run_xact(1'b0, 32'h23, 32'h0, 1'b1, 1'b0, lat, r, e, sb);
    checks++;
    if (r !== 32'h00000011 || e !== 1'b0) begin
      errors++;
      $display("FAIL byteload23 rd %h/00000011 err %b/0", r, e);
    end
    byt = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] er, r;
    logic        ee, e;
    int          lat, sb;
    req  = 1'b1;
    we   = 1'b1;
    addr = 32'h14;
    wd   = ~model[5];
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    last_rd = RST_RD;
    checks++;
    if (rdy !== 1'b0 || rd !== RST_RD || err !== 1'b0) begin
      errors++;
      $display("FAIL midreset rdy=%b rd=%h err=%b exp 0 %h 0",
               rdy, rd, err, RST_RD);
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    prev_keep = 1'b0;
    model_xact(1'b0, 32'h14, 32'h0, 1'b0, er, ee);
    run_xact(1'b0, 32'h14, 32'h0, 1'b0, 1'b0, lat, r, e, sb);
    checks++;
    if (lat !== WS + 1 || r !== er || e !== 1'b0 || sb != 0) begin
      errors++;
      $display("FAIL postreset lat %0d/%0d rd %h/%h err %b/0 stallbad %0d",
               lat, WS + 1, r, er, e, sb);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] v;
    v  = $urandom;
    zq = 1'b1;
    zw = 1'b1;
    za = 32'h4;
    zd = v;
    #1;
    checks++;
    if (zs !== 1'b1 || zy !== 1'b0) begin
      errors++;
      $display("FAIL z_idle stall=%b/1 rdy=%b/0", zs, zy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (zy !== 1'b1 || ze !== 1'b0 || zs !== 1'b0) begin
      errors++;
      $display("FAIL z_store rdy=%b/1 err=%b/0 stall=%b/0", zy, ze, zs);
    end
    zq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (zy !== 1'b0) begin
      errors++;
      $display("FAIL z_pulse rdy=%b/0", zy);
    end
    zq = 1'b1;
    zw = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (zy !== 1'b1 || zr !== v || ze !== 1'b0 || zs !== 1'b0) begin
      errors++;
      $display("FAIL z_load rdy=%b/1 rd=%h/%h err=%b/0 stall=%b/0",
               zy, zr, v, ze, zs);
    end
    za = 32'h40;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (zy !== 1'b1 || ze !== 1'b1 || zr !== RST_RD) begin
      errors++;
      $display("FAIL z_range rdy=%b/1 err=%b/1 rd=%h/%h", zy, ze, zr, RST_RD);
    end
    zq = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset     = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wd        = '0;
    zq        = 1'b0;
    zw        = 1'b0;
    za        = '0;
    zd        = '0;
`ifdef DMEM_BYTE_ACCESS_EN
    byt       = 1'b0;
    zb        = 1'b0;
`endif
    last_rd   = RST_RD;
    prev_keep = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_fill();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_random();
`ifdef DMEM_BYTE_ACCESS_EN
    test_byte();
`endif
    test_reset_mid();
    test_zero_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
